// File: rtl/fifo_sync_fwft_if.sv
// fifo_sync_fwft_if
//   Handshake and status bundle for fifo_sync_fwft.
//   slave  : the FIFO side (consumes i_*, drives o_*)
//   master : the user side (drives i_*, observes o_*)
//   i_flush            synchronous clear
//   i_wr / i_data      write request and write word
//   i_rd               read request (standard) or head acknowledge (FWFT)
//   o_data / o_valid   read word and its qualifier
//   o_fill             stored word count, 0..2^ADDR_WIDTH
//   o_full, o_almostfull, o_empty, o_almostempty   level flags
//   o_overflow, o_underflow                        sticky error flags
interface fifo_sync_fwft_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
);
    logic                  i_flush;
    logic                  i_wr;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  i_rd;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic [ADDR_WIDTH:0]   o_fill;
    logic                  o_full;
    logic                  o_almostfull;
    logic                  o_empty;
    logic                  o_almostempty;
    logic                  o_overflow;
    logic                  o_underflow;

    modport master (
        output i_flush, i_wr, i_data, i_rd,
        input  o_data, o_valid, o_fill, o_full, o_almostfull,
               o_empty, o_almostempty, o_overflow, o_underflow
    );

    modport slave (
        input  i_flush, i_wr, i_data, i_rd,
        output o_data, o_valid, o_fill, o_full, o_almostfull,
               o_empty, o_almostempty, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_sync_fwft.sv
// fifo_sync_fwft
//   Single-clock FIFO of 2^ADDR_WIDTH words with a selectable read style.
//   FWFT=0: a read request on a non-empty FIFO returns the head word on
//           o_data one cycle later, qualified by a one-cycle o_valid pulse.
//   FWFT=1: the head word sits on o_data while o_valid is high; i_rd
//           acknowledges it and the next word appears after the same edge.
//   Ports:
//     i_clk  clock, rising edge
//     i_rst  asynchronous active-high reset of pointers and status
//     bus    fifo_sync_fwft_if.slave (flush, write, read, data and flags)
module fifo_sync_fwft #(
    parameter int DATA_WIDTH         = 8,
    parameter int ADDR_WIDTH         = 9,
    parameter int FWFT               = 0,
    parameter int ALMOSTFULL_OFFSET  = 2,
    parameter int ALMOSTEMPTY_OFFSET = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    fifo_sync_fwft_if.slave  bus
);

    localparam int                  DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FILL_MAX = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_LVL   = (ADDR_WIDTH+1)'(DEPTH - ALMOSTFULL_OFFSET);
    localparam logic [ADDR_WIDTH:0] AE_LVL   = (ADDR_WIDTH+1)'(ALMOSTEMPTY_OFFSET);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [ADDR_WIDTH:0]   fill, fill_after_rd, fill_nxt;
    logic                  full, empty;
    logic                  wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;
    logic                  valid_q, valid_nxt;
    logic                  ovf_q, unf_q;

    assign full  = (fill == FILL_MAX);
    assign empty = (fill == '0);

    // In FWFT mode o_valid is high exactly when fill != 0, so both
    // acceptance forms agree; the mode split keeps the intent explicit.
    assign wr_ok = bus.i_wr && !full;
    assign rd_ok = (FWFT != 0) ? (bus.i_rd && valid_q) : (bus.i_rd && !empty);

    assign rd_ptr_nxt    = rd_ptr + ADDR_WIDTH'(rd_ok);
    assign fill_after_rd = fill - (ADDR_WIDTH+1)'(rd_ok);
    assign fill_nxt      = fill_after_rd + (ADDR_WIDTH+1)'(wr_ok);

    // Next read-side register contents.
    // FWFT: the word at the post-edge head. If words remain after the read
    // they already sit in memory at rd_ptr_nxt; if none remain but a write
    // lands on this edge, that write becomes the head, so bypass i_data.
    // Standard: load the head on an accepted read, otherwise hold.
    always_comb begin
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        if (FWFT != 0) begin
            if (fill_after_rd != '0) begin
                data_nxt  = mem[rd_ptr_nxt];
                valid_nxt = 1'b1;
            end else if (wr_ok) begin
                data_nxt  = bus.i_data;
                valid_nxt = 1'b1;
            end
        end else begin
            if (rd_ok) begin
                data_nxt  = mem[rd_ptr];
                valid_nxt = 1'b1;
            end
        end
    end

    // Storage is never reset; only pointers and status are.
    always_ff @(posedge i_clk) begin
        if (wr_ok && !bus.i_flush)
            mem[wr_ptr] <= bus.i_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (bus.i_flush) begin
            // Flush overrides this cycle's wr/rd; o_data keeps its value.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill    <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr  <= rd_ptr_nxt;
            fill    <= fill_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ovf_q   <= ovf_q | (bus.i_wr && full);
            unf_q   <= unf_q | (bus.i_rd && !rd_ok);
        end
    end

    assign bus.o_data        = data_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_fill        = fill;
    assign bus.o_full        = full;
    assign bus.o_empty       = empty;
    assign bus.o_almostfull  = (fill >= AF_LVL);
    assign bus.o_almostempty = (fill <= AE_LVL);
    assign bus.o_overflow    = ovf_q;
    assign bus.o_underflow   = unf_q;

endmodule

// File: doc/fifo_sync_fwft.md
FIFO_SYNC_FWFT -- requirements
Module: fifo_sync_fwft

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 9: depth is DEPTH = 2^ADDR_WIDTH words.
REQ-003 Parameter FWFT, default 0: 0 selects standard read mode, 1 selects first-word-fall-through mode.
REQ-004 Parameter ALMOSTFULL_OFFSET, default 2: almost-full threshold below DEPTH.
REQ-005 Parameter ALMOSTEMPTY_OFFSET, default 2: almost-empty threshold.
REQ-006 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 i_rst  in  1  reset, asynchronous, active-high.
REQ-008 i_flush  in  1  synchronous clear of contents and sticky flags.
REQ-009 i_wr  in  1  write request.
REQ-010 i_data  in  DATA_WIDTH  write data.
REQ-011 i_rd  in  1  read request (standard mode) or head acknowledge (FWFT).
REQ-012 o_data  out  DATA_WIDTH  read data.
REQ-013 o_valid  out  1  standard: accepted-read data pulse; FWFT: head word present on o_data.
REQ-014 o_fill  out  ADDR_WIDTH+1  stored word count.
REQ-015 o_full, o_almostfull, o_empty, o_almostempty  out  1 each  status flags.
REQ-016 o_overflow, o_underflow  out  1 each  sticky error flags.

Function
REQ-017 Write acceptance SHALL be wr_ok = i_wr && !o_full; a rejected write SHALL leave memory, pointer and o_fill unchanged.
REQ-018 Read acceptance SHALL be rd_ok = i_rd && !o_empty in standard mode, and i_rd && o_valid in FWFT mode.
REQ-019 Write and read pointers SHALL be ADDR_WIDTH bits, advance by 1 per accepted operation, and wrap from DEPTH-1 to 0.
REQ-020 o_fill SHALL increment on wr_ok only, decrement on rd_ok only, and hold on both or neither; it SHALL never leave 0..DEPTH.
REQ-021 o_full = (o_fill == DEPTH); o_empty = (o_fill == 0); o_almostfull = (o_fill >= DEPTH-ALMOSTFULL_OFFSET); o_almostempty = (o_fill <= ALMOSTEMPTY_OFFSET).
REQ-022 When full, simultaneous i_wr and i_rd: read accepted, write rejected, o_fill becomes DEPTH-1.
REQ-023 When empty, simultaneous i_wr and i_rd: write accepted, read rejected, o_fill becomes 1.
REQ-024 Standard mode: on an rd_ok edge, o_data SHALL load the head word and o_valid SHALL be 1 for exactly the following cycle; otherwise o_data holds and o_valid = 0.
REQ-025 FWFT mode: o_valid SHALL rise one cycle after the edge that wrote into an empty FIFO, with o_data already equal to that word.
REQ-026 FWFT mode: on rd_ok, o_data SHALL present the next word after that same edge with o_valid kept high if the FIFO still holds words, so one word per cycle is sustained; otherwise o_valid SHALL drop.
REQ-027 FWFT mode: while o_valid = 1 and no rd_ok occurs, o_data SHALL hold stable.
REQ-028 FWFT mode: o_fill SHALL count the word presented on o_data.
REQ-029 o_overflow SHALL set on i_wr && o_full; o_underflow SHALL set on i_rd with the read rejected; both SHALL hold until reset or flush.
REQ-030 i_flush SHALL, at the next edge, zero pointers, o_fill, o_valid, o_overflow and o_underflow, and override i_wr and i_rd in that cycle; o_data holds.
REQ-031 Memory contents SHALL not be reset; only pointers and status are reset.

Reset
REQ-032 Asserting i_rst SHALL immediately, without a clock, zero pointers, o_fill, o_valid, o_overflow, o_underflow and o_data; o_empty and o_almostempty become 1, o_full and o_almostfull become 0.
REQ-033 After i_rst deasserts, the first operation SHALL be accepted at the next rising edge; reset mid-stream SHALL discard all stored words.

Verification
REQ-034 Standard mode, DEPTH 4: write 0xA1,0xA2; read once -> o_valid for 1 cycle with o_data 0xA1, o_fill 1.
REQ-035 FWFT mode: write 0x55 into empty -> o_valid=1, o_data=0x55 one cycle later; continuous i_rd with back-to-back writes -> one word per cycle in order.
REQ-036 DEPTH 4: write 5 words -> o_full=1 at fill 4, 5th rejected, o_overflow=1; then i_wr+i_rd together -> fill 3.
REQ-037 Empty FIFO: i_rd pulse -> o_underflow=1, o_fill stays 0; i_flush -> o_underflow=0.
REQ-038 Write and read 2*DEPTH+3 words (pointer wrap) -> data order preserved, o_almostfull and o_almostempty thresholds correct at each fill.
REQ-039 Fill to 3, assert i_rst between edges -> outputs zero immediately; after release, a new write reads back correctly.
